reflock_lock_ctrl: RTL and testbench

- Lock-status controller for the RefLock II CPLD, which locks the 144.075 MHz VCO to the 10 MHz reference.
- Counts rising edges of the prescaled VCO (vco_div) over a fixed gate timed by the 10 MHz refClock, then compares each count against an expected value within a tolerance window.
- A small state machine with hysteresis declares signal-present and locked; the result drives LED1/LED2 and exposes steer hints (too_fast/too_slow).

---
 rtl/reflock_lock_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_reflock_lock_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reflock_lock_ctrl.sv
// -----------------------------------------------------------------------------
// reflock_lock_ctrl
//
// Lock-status controller for the RefLock II. The prescaled VCO (vco_div) is
// synchronised into the refClock domain and its rising edges are counted over
// a fixed gate of GATE_CYCLES reference cycles. Each completed gate count is
// classified against EXPECTED +/- TOL. A small hysteresis state machine then
// decides whether a signal is present and whether the loop is locked.
//
// Ports:
//   refClock     in   10 MHz reference clock (only clock)
//   reset        in   asynchronous active-high reset
//   vco_div      in   prescaled VCO, asynchronous to refClock
//   count        out  [15:0] edge count of the last completed gate
//   count_valid  out  one-cycle pulse when count updates
//   too_fast     out  last count above EXPECTED+TOL
//   too_slow     out  last count below EXPECTED-TOL
//   locked       out  high while in the LOCKED state
//   LED1         out  signal present (state is not NOSIG)
//   LED2         out  same as locked
// -----------------------------------------------------------------------------
module reflock_lock_ctrl #(
    parameter int GATE_CYCLES  = 10000,
    parameter int EXPECTED     = 2251,
    parameter int TOL          = 2,
    parameter int LOCK_GATES   = 4,
    parameter int UNLOCK_GATES = 2
) (
    input  logic        refClock,
    input  logic        reset,
    input  logic        vco_div,
    output logic [15:0] count,
    output logic        count_valid,
    output logic        too_fast,
    output logic        too_slow,
    output logic        locked,
    output logic        LED1,
    output logic        LED2
);

    typedef enum logic [1:0] {
        ST_NOSIG   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(GATE_CYCLES - 1);
    localparam int          HI_INT   = EXPECTED + TOL;
    // A window reaching below zero is clamped so that the compare stays sane.
    localparam int          LO_INT   = (EXPECTED - TOL < 0) ? 0 : (EXPECTED - TOL);
    localparam logic signed [16:0] HI_S = 17'(HI_INT);
    localparam logic signed [16:0] LO_S = 17'(LO_INT);
    localparam logic [3:0]  LOCK_CMP   = 4'(LOCK_GATES);
    localparam logic [3:0]  UNLOCK_CMP = 4'(UNLOCK_GATES);

    // Synchroniser and edge-detect flops
    logic sync1_q, sync2_q, sync3_q;
    logic vco_rise;

    // Gate timing
    logic [15:0] gate_idx_q, gate_idx_d;
    logic [15:0] acc_q, acc_d;

    // Registered results
    logic [15:0] count_q, count_d;
    logic        count_valid_q, count_valid_d;
    logic        too_fast_q, too_fast_d;
    logic        too_slow_q, too_slow_d;
    logic        locked_q, locked_d;
    logic        led1_q, led1_d;

    // Lock state machine
    state_t      state_q, state_d;
    logic [3:0]  good_run_q, good_run_d;
    logic [3:0]  bad_run_q, bad_run_d;

    // Combinational helpers
    logic [16:0]        sum17;
    logic [15:0]        gate_val;
    logic signed [16:0] val_s;
    logic               gate_end;
    logic               is_zero, in_win, over, under;
    logic [3:0]         good_inc, bad_inc;

    assign vco_rise = sync2_q & ~sync3_q;

    always_comb begin
        // Gate-end value includes an edge landing in the closing cycle.
        sum17    = {1'b0, acc_q} + {16'd0, vco_rise};
        gate_val = sum17[16] ? 16'hFFFF : sum17[15:0];
        gate_end = (gate_idx_q == LAST_IDX);

        gate_idx_d = gate_end ? 16'd0 : (gate_idx_q + 16'd1);
        acc_d      = gate_end ? 16'd0 : gate_val;

        val_s   = {1'b0, gate_val};
        is_zero = (gate_val == 16'd0);
        over    = (val_s > HI_S);
        under   = (val_s < LO_S);
        in_win  = ~over & ~under;

        good_inc = (good_run_q == 4'hF) ? 4'hF : (good_run_q + 4'd1);
        bad_inc  = (bad_run_q  == 4'hF) ? 4'hF : (bad_run_q  + 4'd1);

        count_d       = count_q;
        count_valid_d = 1'b0;
        too_fast_d    = too_fast_q;
        too_slow_d    = too_slow_q;
        state_d       = state_q;
        good_run_d    = good_run_q;
        bad_run_d     = bad_run_q;

        if (gate_end) begin
            count_d       = gate_val;
            count_valid_d = 1'b1;
            too_fast_d    = over;
            too_slow_d    = under;

            case (state_q)
                ST_NOSIG: begin
                    if (!is_zero) begin
                        // Entry gate seeds the run but never locks by itself.
                        state_d    = ST_ACQUIRE;
                        good_run_d = in_win ? 4'd1 : 4'd0;
                    end
                end
                ST_ACQUIRE: begin
                    if (is_zero) begin
                        state_d    = ST_NOSIG;
                        good_run_d = 4'd0;
                    end else if (in_win) begin
                        good_run_d = good_inc;
                        if (good_inc >= LOCK_CMP) begin
                            state_d   = ST_LOCKED;
                            bad_run_d = 4'd0;
                        end
                    end else begin
                        good_run_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (is_zero) begin
                        // Loss of signal drops lock immediately.
                        state_d    = ST_NOSIG;
                        good_run_d = 4'd0;
                        bad_run_d  = 4'd0;
                    end else if (in_win) begin
                        bad_run_d = 4'd0;
                    end else begin
                        bad_run_d = bad_inc;
                        if (bad_inc >= UNLOCK_CMP) begin
                            state_d    = ST_ACQUIRE;
                            good_run_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d    = ST_NOSIG;
                    good_run_d = 4'd0;
                    bad_run_d  = 4'd0;
                end
            endcase
        end

        // Status outputs are registered from the next state so they move
        // together with count.
        locked_d = (state_d == ST_LOCKED);
        led1_d   = (state_d != ST_NOSIG);
    end

    always_ff @(posedge refClock or posedge reset) begin
        if (reset) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            gate_idx_q    <= 16'd0;
            acc_q         <= 16'd0;
            count_q       <= 16'd0;
            count_valid_q <= 1'b0;
            too_fast_q    <= 1'b0;
            too_slow_q    <= 1'b0;
            locked_q      <= 1'b0;
            led1_q        <= 1'b0;
            state_q       <= ST_NOSIG;
            good_run_q    <= 4'd0;
            bad_run_q     <= 4'd0;
        end else begin
            sync1_q       <= vco_div;
            sync2_q       <= sync1_q;
            sync3_q       <= sync2_q;
            gate_idx_q    <= gate_idx_d;
            acc_q         <= acc_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            too_fast_q    <= too_fast_d;
            too_slow_q    <= too_slow_d;
            locked_q      <= locked_d;
            led1_q        <= led1_d;
            state_q       <= state_d;
            good_run_q    <= good_run_d;
            bad_run_q     <= bad_run_d;
        end
    end

    assign count       = count_q;
    assign count_valid = count_valid_q;
    assign too_fast    = too_fast_q;
    assign too_slow    = too_slow_q;
    assign locked      = locked_q;
    assign LED1        = led1_q;
    assign LED2        = locked_q;

endmodule

// File: tb/tb_reflock_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reflock_lock_ctrl
//
// Directed bench for reflock_lock_ctrl with a 1000-cycle gate, 225 nominal
// edges and a +/-2 window. Each gate is driven with an exact number of
// vco_div pulses placed by gate index, and the gate-end outputs are compared
// with hand-computed values. One line is printed per gate.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_reflock_lock_ctrl;

    logic        refClock;
    logic        reset;
    logic        vco_div;
    logic [15:0] count;
    logic        count_valid;
    logic        too_fast;
    logic        too_slow;
    logic        locked;
    logic        LED1;
    logic        LED2;

    int total_cnt = 0;
    int bad_cnt   = 0;

    reflock_lock_ctrl #(
        .GATE_CYCLES (1000),
        .EXPECTED    (225),
        .TOL         (2),
        .LOCK_GATES  (4),
        .UNLOCK_GATES(2)
    ) dut (
        .refClock   (refClock),
        .reset      (reset),
        .vco_div    (vco_div),
        .count      (count),
        .count_valid(count_valid),
        .too_fast   (too_fast),
        .too_slow   (too_slow),
        .locked     (locked),
        .LED1       (LED1),
        .LED2       (LED2)
    );

    initial refClock = 1'b0;
    always #50 refClock = ~refClock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pin level driven during the cycle after the posedge at gate index c.
    // A rise driven at index c is counted by the DUT at index c+3.
    // Regular pulses rise at 2,6,10,... (high 2 cycles, low 2 cycles).
    // late : extra pulse rising at 996 -> counted at index 999 of this gate.
    // early: extra pulse rising at 997 -> counted at index 0 of the next gate.
    function automatic logic pat(input int c, input int n, input bit late, input bit early);
        logic v;
        v = (c >= 2) && (((c - 2) % 4) < 2) && (((c - 2) / 4) < n);
        if (late  && (c == 996 || c == 997)) v = 1'b1;
        if (early && (c == 997 || c == 998)) v = 1'b1;
        return v;
    endfunction

    // Runs one gate. Must be entered just before the posedge at gate index 0.
    task automatic run_gate(input string name, input int n, input bit late, input bit early,
                            input int e_cnt, input bit e_fast, input bit e_slow,
                            input bit e_lock, input bit e_led1);
        for (int c = 0; c < 1000; c++) begin
            @(posedge refClock);
            #1;
            vco_div = pat(c, n, late, early);
            if (c == 500) chk({name, ".cv_mid"}, count_valid, 1'b0);
            if (c == 998) chk({name, ".cv_pre"}, count_valid, 1'b0);
            if (c == 999) begin
                chk({name, ".cv"},       count_valid, 1'b1);
                chk({name, ".count"},    count,       e_cnt);
                chk({name, ".too_fast"}, too_fast,    e_fast);
                chk({name, ".too_slow"}, too_slow,    e_slow);
                chk({name, ".locked"},   locked,      e_lock);
                chk({name, ".LED2"},     LED2,        e_lock);
                chk({name, ".LED1"},     LED1,        e_led1);
                $display("gate %s: count=%0d fast=%0b slow=%0b locked=%0b led1=%0b",
                         name, count, too_fast, too_slow, locked, LED1);
            end
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".count"},    count,       16'd0);
        chk({name, ".cv"},       count_valid, 1'b0);
        chk({name, ".too_fast"}, too_fast,    1'b0);
        chk({name, ".too_slow"}, too_slow,    1'b0);
        chk({name, ".locked"},   locked,      1'b0);
        chk({name, ".LED1"},     LED1,        1'b0);
        chk({name, ".LED2"},     LED2,        1'b0);
    endtask

    initial begin
        reset   = 1'b1;
        vco_div = 1'b0;
        repeat (4) @(posedge refClock);
        #20;
        chk_all_zero("reset");
        $display("reset state checked");
        @(negedge refClock);
        reset = 1'b0;

        // 1: no signal
        for (int g = 0; g < 5; g++)
            run_gate($sformatf("nosig%0d", g), 0, 0, 0, 0, 0, 1, 0, 0);

        // 2: nominal signal; NOSIG->ACQUIRE seeds good_run=1, locks on 4th good gate
        run_gate("acq1", 225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("acq2", 225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("acq3", 225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("acq4", 225, 0, 0, 225, 0, 0, 1, 1);
        run_gate("acq5", 225, 0, 0, 225, 0, 0, 1, 1);

        // 3: three fast gates, unlock after the second, then relock
        run_gate("fast1", 230, 0, 0, 230, 1, 0, 1, 1);
        run_gate("fast2", 230, 0, 0, 230, 1, 0, 0, 1);
        run_gate("fast3", 230, 0, 0, 230, 1, 0, 0, 1);
        run_gate("rel1",  225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("rel2",  225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("rel3",  225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("rel4",  225, 0, 0, 225, 0, 0, 1, 1);

        // Window edges while locked: 227/223 inside, 228/222 outside
        run_gate("hi_in",  227, 0, 0, 227, 0, 0, 1, 1);
        run_gate("lo_in",  223, 0, 0, 223, 0, 0, 1, 1);
        run_gate("hi_out", 228, 0, 0, 228, 1, 0, 1, 1);
        run_gate("good_a", 225, 0, 0, 225, 0, 0, 1, 1);
        run_gate("lo_out", 222, 0, 0, 222, 0, 1, 1, 1);
        run_gate("good_b", 225, 0, 0, 225, 0, 0, 1, 1);

        // 4: alternating bad/good keeps lock
        run_gate("alt1", 230, 0, 0, 230, 1, 0, 1, 1);
        run_gate("alt2", 225, 0, 0, 225, 0, 0, 1, 1);
        run_gate("alt3", 230, 0, 0, 230, 1, 0, 1, 1);
        run_gate("alt4", 225, 0, 0, 225, 0, 0, 1, 1);

        // 5: gate boundary edges
        run_gate("late",   225, 1, 0, 226, 0, 0, 1, 1);
        run_gate("early",  224, 0, 1, 224, 0, 0, 1, 1);
        run_gate("carry",  224, 0, 0, 225, 0, 0, 1, 1);

        // 6: reset at gate index 500 while locked
        for (int c = 0; c <= 500; c++) begin
            @(posedge refClock);
            #1;
            vco_div = pat(c, 225, 0, 0);
        end
        chk("pre_rst.locked", locked, 1'b1);
        #10;
        reset   = 1'b1;
        vco_div = 1'b0;
        #1;
        chk_all_zero("async_rst");
        $display("mid-gate reset checked");
        repeat (3) @(posedge refClock);
        @(negedge refClock);
        reset = 1'b0;
        run_gate("post1", 225, 0, 0, 225, 0, 0, 0, 1);
        run_gate("post0", 0,   0, 0, 0,   0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
